// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
package decoder_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bus between the requesters and the arbiter.
interface decoder_rr_arbiter_if;
    import decoder_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_en;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timeout;

    // Requester side drives req/done and observes the grant.
    modport master (
        output req, done,
        input  grant_idx, grant_en, grant, busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, done,
        output grant_idx, grant_en, grant, busy, timeout
    );
endinterface

// File: rtl/decoder.sv
// 3-to-8 decoder output stage: one-hot S from select A, all-zero when E is low.
module Decoder (
    input  logic [2:0] A,
    input  logic       E,
    output logic [7:0] S
);
    // One-hot decode gated by the enable.
    always_comb begin
        S = '0;
        if (E) S = 8'(1) << A;
    end
endmodule

// File: rtl/rr_priority_pick.sv
// Rotating-priority selector: first set request at or after ptr, wrapping 7 -> 0.
module rr_priority_pick
    import decoder_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] cand;

    // Scan upward from ptr; the modulo-8 wrap comes from the 3-bit add.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among eight requesters.
// A grant is held until the owner releases it or MAX_HOLD cycles elapse.
module decoder_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_rr_arbiter_if.slave  bus
);
    import decoder_arb_pkg::*;

    // The decoder select is 3 bits wide, so only an 8-way arbiter is meaningful.
    if (N_REQ != decoder_arb_pkg::N_REQ || IDX_W != decoder_arb_pkg::IDX_W) begin : g_bad_width
        $error("decoder_rr_arbiter: N_REQ must be 8 and IDX_W must be 3");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
        $error("decoder_rr_arbiter: MAX_HOLD must be in 2..256");
    end

    localparam int              HC_W      = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_en_q, grant_en_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             rel_done, rel_drop, rel_limit;

    rr_priority_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Only the owner's done/req bits can end a grant.
    assign rel_done  = bus.done[grant_idx_q];
    assign rel_drop  = !bus.req[grant_idx_q];
    assign rel_limit = (hold_cnt_q == HOLD_LAST);

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_idx_q <= '0;
            grant_en_q  <= 1'b0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_en_q  <= grant_en_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold in GRANT, advance ptr in RELEASE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        grant_en_d  = grant_en_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    grant_en_d  = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    grant_en_d = 1'b0;
                    // An owner release on the limit edge wins over the timeout.
                    timeout_d  = rel_limit && !rel_done && !rel_drop;
                    state_d    = RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            RELEASE: begin
                // Last owner drops to lowest priority in the next arbitration.
                ptr_d   = grant_idx_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                grant_en_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign bus.grant_idx = grant_idx_q;
    assign bus.grant_en  = grant_en_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.timeout   = timeout_q;

    Decoder u_dec (
        .A (grant_idx_q),
        .E (grant_en_q),
        .S (bus.grant)
    );
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed test bench for decoder_rr_arbiter with hand-computed expectations.
module tb_decoder_rr_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(
        .N_REQ    (8),
        .IDX_W    (3),
        .MAX_HOLD (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, released between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int cnt;
    logic [7:0] exp_oh;
    logic [2:0] exp_idx;

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.done = '0;

        // 1: reset, then idle for 10 cycles
        #2;
        chk("rst_grant_en", 32'(bus.grant_en), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'h00);
        chk("rst_idx", 32'(bus.grant_idx), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_grant", 32'({bus.grant_en, bus.busy, bus.timeout, bus.grant}), 32'd0);
        end

        // 2: single requester 3
        bus.req = 8'h08;
        step();
        chk("single_idx", 32'(bus.grant_idx), 32'd3);
        chk("single_grant", 32'(bus.grant), 32'h08);
        chk("single_busy", 32'(bus.busy), 32'd1);
        bus.done = 8'hF7;              // other owners' done must be ignored
        step();
        chk("foreign_done", 32'(bus.grant), 32'h08);
        bus.done = 8'h00;
        step();
        step();
        chk("single_c4", 32'(bus.grant), 32'h08);
        bus.done = 8'h08;
        step();
        chk("single_rel_grant", 32'(bus.grant), 32'h00);
        chk("single_rel_busy", 32'(bus.busy), 32'd1);
        chk("single_rel_to", 32'(bus.timeout), 32'd0);
        bus.done = 8'h00;
        step();
        chk("single_idle_grant", 32'(bus.grant), 32'h00);
        chk("single_idle_busy", 32'(bus.busy), 32'd0);
        step();
        chk("single_regrant", 32'(bus.grant), 32'h08);

        // 3: round robin over all eight, wrapping to 0
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            exp_idx = 3'(k % 8);
            exp_oh  = 8'(1) << exp_idx;
            chk("rr_idx", 32'(bus.grant_idx), 32'(exp_idx));
            chk("rr_grant", 32'(bus.grant), 32'(exp_oh));
            step();
            bus.done = exp_oh;
            step();
            chk("rr_dead1", 32'(bus.grant_en), 32'd0);
            bus.done = 8'h00;
            step();
            chk("rr_dead2", 32'(bus.grant_en), 32'd0);
            step();
        end

        // 4: wrap and priority with ptr at 6
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'h20;
        step();
        chk("wrap_owner5", 32'(bus.grant_idx), 32'd5);
        bus.done = 8'h20;
        step();
        bus.done = 8'h00;
        bus.req  = 8'h41;
        step();
        step();
        chk("wrap_idx6", 32'(bus.grant_idx), 32'd6);
        chk("wrap_grant6", 32'(bus.grant), 32'h40);
        bus.done = 8'h40;
        step();
        bus.done = 8'h00;
        step();
        step();
        chk("wrap_idx0", 32'(bus.grant_idx), 32'd0);
        chk("wrap_grant0", 32'(bus.grant), 32'h01);

        // 5: hold timeout, then done on the limit edge
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'h04;
        step();
        cnt = (bus.grant_en === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.grant_en !== 1'b1) break;
            chk("to_no_early_pulse", 32'(bus.timeout), 32'd0);
            cnt++;
        end
        chk("to_length", 32'(cnt), 32'd16);
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        chk("to_grant_off", 32'(bus.grant), 32'h00);
        step();
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        step();
        chk("to_regrant_idx", 32'(bus.grant_idx), 32'd2);
        chk("to_regrant_en", 32'(bus.grant_en), 32'd1);
        for (int i = 0; i < 15; i++) step();
        chk("to_limit_cycle", 32'(bus.grant_en), 32'd1);
        bus.done = 8'h04;
        step();
        chk("to_done_rel", 32'(bus.grant_en), 32'd0);
        chk("to_done_nopulse", 32'(bus.timeout), 32'd0);
        bus.done = 8'h00;

        // 6: asynchronous reset mid-grant
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'h20;
        step();
        chk("mid_grant5", 32'(bus.grant), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 32'h00);
        chk("mid_rst_en", 32'(bus.grant_en), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = 8'h21;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_after_idx", 32'(bus.grant_idx), 32'd0);
        chk("mid_after_grant", 32'(bus.grant), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares one 3-to-8 `Decoder` output stage among eight requesters. It selects one requester per grant, drives the decoder's select (`A`) and enable (`E`) from registered state, and holds the grant until the owner releases it or a hold timeout expires. The block sits directly in front of the `Decoder` instance and is its only driver.

## Interface
- `N_REQ`, default 8: number of requesters. Fixed at 8 to match the 3-bit decoder select; any other value is a synthesis error.
- `IDX_W`, default 3: width of the grant index. Equal to clog2(N_REQ).
- `MAX_HOLD`, default 16: maximum cycles a grant may stay in GRANT. Legal range 2..256.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 8: request vector; bit i asserted by requester i.
- `done`, input, 8: release strobe; only bit `grant_idx` is honoured.
- `grant_idx`, output, 3: index of the current owner; drives decoder `A`.
- `grant_en`, output, 1: grant valid; drives decoder `E`.
- `grant`, output, 8: one-hot grant, the decoder output (`S`).
- `busy`, output, 1: high in GRANT and RELEASE.
- `timeout`, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE**
  - If `req` is nonzero, pick the first set bit at or after `ptr`, scanning upward and wrapping 7→0.
  - Register that index into `grant_idx`, set `grant_en=1`, clear `hold_cnt`, go to GRANT.
  - If `req` is zero, stay in IDLE.
- **GRANT**: `hold_cnt` increments each cycle. Release conditions, evaluated at each edge:
  - (a) `done[grant_idx]=1`;
  - (b) `req[grant_idx]=0`;
  - (c) `hold_cnt==MAX_HOLD-1`.
  - On any of these: go to RELEASE and set `grant_en=0`.
  - If (c) holds and neither (a) nor (b) does, assert `timeout` for the RELEASE cycle.
  - Otherwise stay in GRANT.
- **RELEASE**
  - Set `ptr <= grant_idx+1` (mod 8), go to IDLE.
  - `grant_idx` keeps its value; `grant_en` stays 0.
- `grant` is produced by the existing `Decoder` module from `grant_idx`/`grant_en`, so it is all-zero whenever `grant_en=0`.
- `done` bits of requesters other than the owner are ignored. `req` changes on other bits during GRANT do not affect the owner.

## Timing
- Reset values: state IDLE, `ptr=0`, `grant_idx=0`, `grant_en=0`, `grant=0`, `busy=0`, `timeout=0`, `hold_cnt=0`.
- Reset is asynchronous: asserting `rst_n` mid-grant drops `grant_en` and `grant` immediately, with no RELEASE cycle.
- Grant latency: a request visible in IDLE at edge t gives `grant_en=1` in the cycle after edge t (1 cycle).
- A request dropped before the IDLE sampling edge is never granted.
- Gap between consecutive grants: 2 cycles with `grant_en=0` (RELEASE, then IDLE).
- Maximum grant length: `MAX_HOLD` cycles of `grant_en=1`.
- Same-edge conflicts:
  - `done` and the timeout condition together: a normal release with no `timeout` pulse.
  - `req` drop and `done` together: a normal release.
- Fairness: after owner k releases, requester k has the lowest priority in the next arbitration. A requester that stays asserted is granted within 7 intervening grants.
- `hold_cnt` width is clog2(MAX_HOLD). It never wraps because the FSM leaves GRANT at `MAX_HOLD-1`.

## Structure
- Package `decoder_arb_pkg` holds:
  - the state enum (IDLE, GRANT, RELEASE);
  - the constants `N_REQ=8` and `IDX_W=3`.
- Sub-module `rr_priority_pick`: combinational rotating-priority selector. Inputs are `req[7:0]` and `ptr[2:0]`; outputs are `idx[2:0]` and `any`.
- Top level contains the FSM, `ptr`, `hold_cnt` and the output registers, and instantiates `Decoder` for `grant`.

## Test plan
1. Reset then idle. `rst_n=0`, then 1 with `req=0` → all outputs 0 and stays in IDLE for 10 cycles.
2. Single requester. `req=8'h08` → next cycle `grant_idx=3`, `grant=8'h08`. Pulse `done[3]` after 4 cycles → `grant=0` for 2 cycles, then re-granted to 3 while `req[3]` stays high.
3. Round robin. `req=8'hFF` held, each owner pulses `done` after 2 cycles → grant order 0,1,2,…,7,0 with 2 dead cycles between grants.
4. Wrap and priority. `ptr` at 6 (last owner 5), `req=8'h41` → grant 6; after release → grant 0.
5. Timeout. `MAX_HOLD=16`, `req=8'h04` held with no `done` → `grant_en` high for exactly 16 cycles, `timeout` pulses once, then index 2 is re-granted. `done[2]` on the same edge as the limit → no pulse.
6. Mid-grant reset. Grant to 5, then `rst_n=0` asynchronously → `grant` goes to 0 before the next edge. After release of reset, with `req=8'h21` → grant 0 (`ptr` reset to 0).
